freq_ramp_ctrl: RTL and testbench

//  Sequences the frequency code feeding the motor-drive frequency divider (code 0 = 1 Hz .. 49 = 50 Hz).

---
 rtl/freq_ramp_ctrl_pkg.sv | 21 ++
 rtl/ramp_step_timer.sv | 47 ++++
 rtl/freq_ramp_ctrl.sv | 127 ++++++++++++
 tb/tb_freq_ramp_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_ramp_ctrl_pkg.sv
// Shared definitions for the motor frequency ramp controller and the divider
// it feeds: FSM state encoding and the default top frequency code.
package freq_ramp_ctrl_pkg;

  // Highest legal code (50 Hz); the divider sizes its tables from this too.
  localparam int CODE_MAX_DEFAULT = 49;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_HOLD      = 3'd3,
    ST_STOPPING  = 3'd4
  } state_t;

  // States in which the applied code is still moving and steps are timed.
  function automatic logic is_stepping(input state_t s);
    return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN) || (s == ST_STOPPING);
  endfunction

endpackage

// File: rtl/ramp_step_timer.sv
// Ramp-rate prescaler: earns one step credit every STEP_DIV enabled cycles and
// releases it only on a divider period boundary.
module ramp_step_timer #(
  parameter int STEP_DIV = 50000,
  parameter int STEP_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic period_end,
  output logic step
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEP_DIV - 1);

  logic [STEP_W-1:0] prescaler;
  logic              step_due;
  logic              wrap;

  assign wrap = en && (prescaler == LAST);
  assign step = en && step_due && period_end;

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (!en || wrap) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + STEP_W'(1);
    end
  end

  // A single pending credit: further wraps while it waits are dropped, and
  // consuming it takes precedence over a coincident wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_due <= 1'b0;
    end else if (step) begin
      step_due <= 1'b0;
    end else if (wrap) begin
      step_due <= 1'b1;
    end
  end

endmodule

// File: rtl/freq_ramp_ctrl.sv
// Frequency-code sequencer for the motor-drive divider: ramps the applied code
// one step at a time toward the requested target, or down to zero on stop.
module freq_ramp_ctrl
  import freq_ramp_ctrl_pkg::*;
#(
  parameter int CODE_W   = 8,
  parameter int CODE_MAX = CODE_MAX_DEFAULT,
  parameter int STEP_DIV = 50000,
  parameter int STEP_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [CODE_W-1:0] tgt_code,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic              period_end,
  output logic [CODE_W-1:0] freq_code,
  output logic              drive_en,
  output logic              at_speed,
  output logic              busy
);

  localparam logic [CODE_W-1:0] CODE_TOP = CODE_W'(CODE_MAX);

  state_t            state;
  state_t            state_next;
  logic [CODE_W-1:0] target;
  logic [CODE_W-1:0] target_in;
  logic [CODE_W-1:0] code_next;
  logic              drive_next;
  logic              at_speed_next;
  logic              busy_next;
  logic              timer_en;
  logic              step;
  logic              accept;
  logic              inc;
  logic              dec;

  assign tgt_ready = (state != ST_STOPPING);
  assign accept    = tgt_valid && tgt_ready;
  assign target_in = (tgt_code > CODE_TOP) ? CODE_TOP : tgt_code;
  assign timer_en  = is_stepping(state);

  ramp_step_timer #(
    .STEP_DIV (STEP_DIV),
    .STEP_W   (STEP_W)
  ) u_step_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (timer_en),
    .period_end (period_end),
    .step       (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      freq_code <= '0;
      target    <= '0;
      drive_en  <= 1'b0;
      at_speed  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      freq_code <= code_next;
      drive_en  <= drive_next;
      at_speed  <= at_speed_next;
      busy      <= busy_next;
      if (accept) begin
        target <= target_in;
      end
    end
  end

  // Dropping run outranks any target-driven change of direction.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no
    // latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!run)                    state_next = ST_STOPPING;
        else if (freq_code == target) state_next = ST_HOLD;
        else if (target < freq_code)  state_next = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (!run)                    state_next = ST_STOPPING;
        else if (freq_code == target) state_next = ST_HOLD;
        else if (target > freq_code)  state_next = ST_RAMP_UP;
      end
      ST_HOLD: begin
        if (!run)                    state_next = ST_STOPPING;
        else if (target > freq_code) state_next = ST_RAMP_UP;
        else if (target < freq_code) state_next = ST_RAMP_DOWN;
      end
      ST_STOPPING: begin
        if (run)                             state_next = (target < freq_code) ? ST_RAMP_DOWN : ST_RAMP_UP;
        else if (step && freq_code == '0)    state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A step only moves the code while the FSM stays in the same moving state,
  // so leaving a ramp (reached target, reversal, stop) never also steps.
  always_comb begin
    inc = step && (state == ST_RAMP_UP) && (state_next == ST_RAMP_UP)
        && (freq_code < CODE_TOP);
    dec = step && (freq_code != '0)
        && (((state == ST_RAMP_DOWN) && (state_next == ST_RAMP_DOWN))
         || ((state == ST_STOPPING)  && (state_next == ST_STOPPING)));
    code_next = freq_code;
    if (inc) begin
      code_next = freq_code + CODE_W'(1);
    end else if (dec) begin
      code_next = freq_code - CODE_W'(1);
    end
    drive_next    = (state_next != ST_IDLE);
    at_speed_next = (state_next == ST_HOLD);
    busy_next     = is_stepping(state_next);
  end

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Scoreboard bench for freq_ramp_ctrl: a behavioural model predicts every change
// of the output vector; a monitor compares whenever the DUT or model moves.
module tb_freq_ramp_ctrl;

  localparam int STEP_DIV = 4;
  localparam int CMAX     = 49;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] tgt_code = 8'd0;
  logic       tgt_valid = 1'b0;
  logic       period_end = 1'b0;
  logic       tgt_ready;
  logic [7:0] freq_code;
  logic       drive_en;
  logic       at_speed;
  logic       busy;

  bit pe_hold = 1'b0;
  bit pe_random = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  freq_ramp_ctrl #(
    .CODE_W   (8),
    .CODE_MAX (CMAX),
    .STEP_DIV (STEP_DIV),
    .STEP_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .tgt_code   (tgt_code),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .period_end (period_end),
    .freq_code  (freq_code),
    .drive_en   (drive_en),
    .at_speed   (at_speed),
    .busy       (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
  endtask

  // Output vector: {ready, drive_en, at_speed, busy, code[7:0]}
  function automatic int pack(input logic rdy, input logic drv, input logic at,
                              input logic bsy, input logic [7:0] code);
    return int'({20'd0, rdy, drv, at, bsy, code});
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;
  int m_mode, m_code, m_tgt, m_dir, m_presc, m_last;
  bit m_hold, m_due;
  int exp_q[$];

  function automatic int model_vec();
    return pack(m_mode != M_STOP, m_mode != M_IDLE, (m_mode == M_RUN) && m_hold,
                (m_mode == M_STOP) || ((m_mode == M_RUN) && !m_hold), 8'(m_code));
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_code = 0; m_tgt = 0; m_dir = 1; m_presc = 0;
    m_hold = 1'b0; m_due = 1'b0;
    m_last = model_vec();
  endtask

  task automatic model_step();
    bit acc, en, stp, wrap;
    int new_tgt, v;
    acc     = tgt_valid && (m_mode != M_STOP);
    new_tgt = (int'(tgt_code) > CMAX) ? CMAX : int'(tgt_code);
    en      = (m_mode == M_STOP) || ((m_mode == M_RUN) && !m_hold);
    stp     = en && m_due && period_end;
    wrap    = en && (m_presc == STEP_DIV - 1);
    m_presc = (!en || wrap) ? 0 : m_presc + 1;
    if (stp) m_due = 1'b0;
    else if (wrap) m_due = 1'b1;
    case (m_mode)
      M_IDLE: if (run) begin m_mode = M_RUN; m_hold = 1'b0; m_dir = 1; end
      M_RUN: begin
        if (!run) m_mode = M_STOP;
        else if (m_hold) begin
          if (m_tgt != m_code) begin m_hold = 1'b0; m_dir = (m_tgt > m_code) ? 1 : -1; end
        end
        else if (m_code == m_tgt) m_hold = 1'b1;
        else if ((m_tgt - m_code) * m_dir < 0) m_dir = -m_dir;
        else if (stp) m_code = m_code + m_dir;
      end
      default: begin
        if (run) begin m_mode = M_RUN; m_hold = 1'b0; m_dir = (m_tgt < m_code) ? -1 : 1; end
        else if (stp) begin
          if (m_code == 0) m_mode = M_IDLE;
          else m_code = m_code - 1;
        end
      end
    endcase
    if (acc) m_tgt = new_tgt;
    v = model_vec();
    if (v != m_last) begin
      exp_q.push_back(v);
      m_last = v;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int cur, prev, exp_cur;
    bit popped;
    prev = pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    exp_cur = prev;
    forever begin
      @(negedge clk);
      cur = pack(tgt_ready, drive_en, at_speed, busy, freq_code);
      if (!rst_n) begin
        exp_q.delete();
        exp_cur = pack(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      end else begin
        popped = 1'b0;
        if (exp_q.size() > 0) begin
          exp_cur = exp_q.pop_front();
          popped = 1'b1;
        end
        if (popped || cur != prev) check("scoreboard outputs", cur, exp_cur);
      end
      prev = cur;
    end
  end

  // ---------------- period_end source ----------------
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (pe_hold) period_end = 1'b0;
      else if (pe_random) period_end = ($urandom_range(0, 2) == 0);
      else begin
        cnt = (cnt == 2) ? 0 : cnt + 1;
        period_end = (cnt == 2);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_target(input int code);
    tgt_code  = 8'(code);
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_code(input int code, input int budget, input string name);
    int n = 0;
    while (int'(freq_code) != code && n < budget) begin @(negedge clk); n++; end
    check(name, freq_code, code);
  endtask

  task automatic wait_at_speed(input int budget, input string name);
    int n = 0;
    while (!at_speed && n < budget) begin @(negedge clk); n++; end
    check(name, at_speed, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (drive_en && n < budget) begin @(negedge clk); n++; end
    check(name, drive_en, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " freq_code"}, freq_code, 0);
    check({tag, " drive_en"}, drive_en, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " at_speed"}, at_speed, 0);
    check({tag, " tgt_ready"}, tgt_ready, 1);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    run = 1'b0;
    tgt_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f, n;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: start and ramp up to 5
    run = 1'b1;
    send_target(5);
    check("t1 drive_en after 1 clk", drive_en, 1);
    check("t1 busy after 1 clk", busy, 1);
    wait_at_speed(200, "t1 reach hold");
    check("t1 freq_code at hold", freq_code, 5);

    // 2: retarget down to 2
    send_target(2);
    @(negedge clk);
    check("t2 at_speed drops", at_speed, 0);
    wait_at_speed(200, "t2 reach hold");
    check("t2 freq_code at hold", freq_code, 2);

    // 3: out-of-range target clamps to 49
    send_target(200);
    @(negedge clk);
    wait_at_speed(800, "t3 reach hold");
    check("t3 clamped code", freq_code, CMAX);
    repeat (30) @(negedge clk);
    check("t3 stays at max", freq_code, CMAX);

    // 4: stop with a simultaneous target accept
    send_target(3);
    @(negedge clk);
    wait_at_speed(800, "t4 reach 3");
    check("t4 freq_code at 3", freq_code, 3);
    run = 1'b0;
    send_target(10);
    check("t4 tgt_ready in stopping", tgt_ready, 0);
    check("t4 busy in stopping", busy, 1);
    wait_idle(100, "t4 reach idle");
    check("t4 code at idle", freq_code, 0);
    check("t4 tgt_ready at idle", tgt_ready, 1);

    // 5: stored target survives stop; resume from STOPPING; period_end gating
    run = 1'b1;
    @(negedge clk);
    wait_at_speed(200, "t5 reach stored target");
    check("t5 stored target code", freq_code, 10);
    run = 1'b0;
    wait_code(2, 200, "t5 stopping reaches 2");
    run = 1'b1;
    @(negedge clk);
    check("t5 resumed without reaching 0", freq_code, 2);
    check("t5 busy after resume", busy, 1);
    pe_hold = 1'b1;
    repeat (2) @(negedge clk);
    f = freq_code;
    repeat (20) @(negedge clk);
    check("t5 frozen without period_end", freq_code, f);
    pe_hold = 1'b0;
    n = 0;
    while (int'(freq_code) == f && n < 12) begin @(negedge clk); n++; end
    check("t5 single step on release", freq_code, f + 1);

    // 6: asynchronous reset mid-ramp
    wait_code(7, 200, "t6 ramp reaches 7");
    do_reset("t6 async reset");
    @(negedge clk);

    // randomized phase
    pe_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send_target(($urandom_range(0, 3) == 0) ? $urandom_range(50, 255)
                                                         : $urandom_range(0, CMAX));
        3, 4:    run = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
      if (i == 30) begin
        do_reset("random async reset");
        run = 1'b1;
      end
      repeat ($urandom_range(1, 60)) @(negedge clk);
    end
    pe_random = 1'b0;
    run = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
